// File: rtl/game_clock_pkg.sv
// Shared types and helpers for the scoreboard game-clock region.
package game_clock_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned MMSS_W  = 4 * DIGIT_W;

    // Run/pause sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } clk_state_e;

    // One BCD digit
    typedef logic [DIGIT_W-1:0] bcd_t;

    // MM:SS time as four BCD digits, most significant first
    typedef struct packed {
        bcd_t m_tens;
        bcd_t m_ones;
        bcd_t s_tens;
        bcd_t s_ones;
    } mmss_t;

    localparam mmss_t ZERO_TIME = mmss_t'(MMSS_W'(0));

    // True when every digit is a legal BCD value and seconds tens is 0..5
    function automatic logic mmss_valid(input mmss_t t);
        return (t.m_tens <= 4'd9) && (t.m_ones <= 4'd9) &&
               (t.s_tens <= 4'd5) && (t.s_ones <= 4'd9);
    endfunction

endpackage

// File: rtl/mmss_bcd_dec.sv
// Combinational one-second BCD decrement of an MM:SS value, saturating at 00:00.
module mmss_bcd_dec
    import game_clock_pkg::*;
(
    input  mmss_t t_in,
    output mmss_t t_out,
    output logic  is_zero
);

    // Ripple the borrow from seconds ones up through minutes tens
    always_comb begin
        t_out = t_in;
        if (t_in != ZERO_TIME) begin
            if (t_in.s_ones != 4'd0) begin
                t_out.s_ones = t_in.s_ones - 4'd1;
            end else begin
                t_out.s_ones = 4'd9;
                if (t_in.s_tens != 4'd0) begin
                    t_out.s_tens = t_in.s_tens - 4'd1;
                end else begin
                    t_out.s_tens = 4'd5;
                    if (t_in.m_ones != 4'd0) begin
                        t_out.m_ones = t_in.m_ones - 4'd1;
                    end else begin
                        t_out.m_ones = 4'd9;
                        t_out.m_tens = t_in.m_tens - 4'd1;
                    end
                end
            end
        end
        is_zero = (t_out == ZERO_TIME);
    end

endmodule

// File: rtl/game_clock_ctrl.sv
// Game-clock sequencer: MM:SS countdown, run/pause FSM and frame-aligned display shadow.
module game_clock_ctrl
    import game_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 25_000_000,
    parameter logic [7:0]  START_MM = 8'h12,
    parameter logic [7:0]  START_SS = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clock_reset,
    input  logic        load,
    input  logic [15:0] load_time,
    input  logic        frame_start,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        colon_on,
    output logic        running,
    output logic        expired,
    output logic        load_err
);

    localparam int unsigned     PRE_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF  = PRE_W'(CLK_HZ / 2);
    localparam mmss_t           START_TIME = mmss_t'({START_MM, START_SS});

    clk_state_e       state_q, state_d;
    mmss_t            time_q, time_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    mmss_t            dec_time;
    logic             dec_zero;
    logic             count_en;
    logic             expire_c;
    logic             load_err_d;
    logic             colon_c;
    mmss_t            disp_q;
    logic             colon_q;
    logic             running_q;
    logic             expired_q;
    logic             load_err_q;

    mmss_bcd_dec u_dec (
        .t_in    (time_q),
        .t_out   (dec_time),
        .is_zero (dec_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next time/prescaler; clock_reset beats load beats start_stop
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        pre_d      = pre_q;
        load_err_d = 1'b0;
        expire_c   = 1'b0;
        // The prescaler freezes on the cycle a pulse moves us out of RUNNING
        count_en   = (state_q == RUNNING) && !clock_reset && !(start_stop && !load);

        if (clock_reset) begin
            state_d = IDLE;
            time_d  = START_TIME;
            pre_d   = '0;
        end else if (load) begin
            if ((state_q == IDLE) || (state_q == PAUSED)) begin
                if (mmss_valid(mmss_t'(load_time))) begin
                    time_d = mmss_t'(load_time);
                    pre_d  = '0;
                end else begin
                    load_err_d = 1'b1;
                end
            end
        end else if (start_stop) begin
            case (state_q)
                IDLE:    if (time_q != ZERO_TIME) state_d = RUNNING;
                RUNNING: state_d = PAUSED;
                PAUSED:  state_d = RUNNING;
                default: state_d = state_q;
            endcase
        end

        if (count_en) begin
            if (pre_q == PRE_MAX) begin
                pre_d  = '0;
                time_d = dec_time;
                if (dec_zero) begin
                    state_d  = EXPIRED;
                    expire_c = 1'b1;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Colon blinks on-phase first while running, steady otherwise
    always_comb begin
        colon_c = 1'b1;
        if (state_q == RUNNING) begin
            colon_c = (pre_q < PRE_HALF);
        end
    end

    // Countdown time and prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q <= START_TIME;
            pre_q  <= '0;
        end else begin
            time_q <= time_d;
            pre_q  <= pre_d;
        end
    end

    // Status outputs; running drops together with the expiry update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            running_q  <= (state_q == RUNNING) && !expire_c;
            expired_q  <= (state_d == EXPIRED);
            load_err_q <= load_err_d;
        end
    end

    // Display shadow: capture only on frame_start so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q  <= START_TIME;
            colon_q <= 1'b1;
        end else if (frame_start) begin
            disp_q  <= time_q;
            colon_q <= colon_c;
        end
    end

    assign min_tens = disp_q.m_tens;
    assign min_ones = disp_q.m_ones;
    assign sec_tens = disp_q.s_tens;
    assign sec_ones = disp_q.s_ones;
    assign colon_on = colon_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule
